// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage DLX pipeline: per-stage enables,
// flush/bubble controls, EX forwarding selects and saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ready,
  input  logic             mem_ready,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_load,
  input  logic             id_store,
  input  logic             id_pc_cmd_id,
  input  logic             ex_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             bubble_memwb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam logic [FWD_W-1:0] FWD_RF    = FWD_W'(0);
  localparam logic [FWD_W-1:0] FWD_EXMEM = FWD_W'(1);
  localparam logic [FWD_W-1:0] FWD_MEMWB = FWD_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Shadow scoreboard of the instructions in EX, MEM and WB
  logic             v_ex_q, v_ex_d, ld_ex_q, ld_ex_d, st_ex_q, st_ex_d;
  logic [REG_W-1:0] rd_ex_q, rd_ex_d, rs1_ex_q, rs1_ex_d, rs2_ex_q, rs2_ex_d;
  logic             v_mem_q, v_mem_d, ld_mem_q, ld_mem_d, st_mem_q, st_mem_d;
  logic [REG_W-1:0] rd_mem_q, rd_mem_d;
  logic             v_wb_q, v_wb_d;
  logic [REG_W-1:0] rd_wb_q, rd_wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic mem_wait_c, redirect_c, load_use_c;

  assign mem_wait_c = v_mem_q && (ld_mem_q || st_mem_q) && !mem_ready;
  assign redirect_c = ex_taken && v_ex_q;
  assign load_use_c = v_ex_q && ld_ex_q && (rd_ex_q != '0) &&
                      ((rd_ex_q == id_rs1) || (rd_ex_q == id_rs2));

  // Priority-ordered hazard resolution
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    flush_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    bubble_memwb = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      flush_ifid   = 1'b1;
      bubble_idex  = 1'b1;
      bubble_memwb = 1'b1;
    end else if (mem_wait_c) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      bubble_memwb = 1'b1;
    end else if (redirect_c) begin
      flush_ifid   = 1'b1;
      bubble_idex  = 1'b1;
    end else if (load_use_c) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      bubble_idex  = 1'b1;
    end else if (id_pc_cmd_id) begin
      pc_en        = i_ready;
      flush_ifid   = 1'b1;
    end else if (!i_ready) begin
      pc_en        = 1'b0;
      flush_ifid   = 1'b1;
    end
  end

  // Forwarding for the EX instruction; a load in MEM has no result on EX/MEM yet
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!reset) begin
      if (v_mem_q && !ld_mem_q && (rd_mem_q != '0) && (rd_mem_q == rs1_ex_q)) begin
        fwd_a = FWD_EXMEM;
      end else if (v_wb_q && (rd_wb_q != '0) && (rd_wb_q == rs1_ex_q)) begin
        fwd_a = FWD_MEMWB;
      end
      if (v_mem_q && !ld_mem_q && (rd_mem_q != '0) && (rd_mem_q == rs2_ex_q)) begin
        fwd_b = FWD_EXMEM;
      end else if (v_wb_q && (rd_wb_q != '0) && (rd_wb_q == rs2_ex_q)) begin
        fwd_b = FWD_MEMWB;
      end
    end
  end

  // Scoreboard advance: entries move only on edges where their stage enable is set
  always_comb begin
    v_ex_d   = v_ex_q;
    rd_ex_d  = rd_ex_q;
    rs1_ex_d = rs1_ex_q;
    rs2_ex_d = rs2_ex_q;
    ld_ex_d  = ld_ex_q;
    st_ex_d  = st_ex_q;
    v_mem_d  = v_mem_q;
    rd_mem_d = rd_mem_q;
    ld_mem_d = ld_mem_q;
    st_mem_d = st_mem_q;
    v_wb_d   = v_wb_q;
    rd_wb_d  = rd_wb_q;
    if (idex_en) begin
      v_ex_d   = !bubble_idex;
      rd_ex_d  = bubble_idex ? '0 : id_rd;
      rs1_ex_d = bubble_idex ? '0 : id_rs1;
      rs2_ex_d = bubble_idex ? '0 : id_rs2;
      ld_ex_d  = !bubble_idex && id_load;
      st_ex_d  = !bubble_idex && id_store;
    end
    if (exmem_en) begin
      v_mem_d  = v_ex_q;
      rd_mem_d = rd_ex_q;
      ld_mem_d = ld_ex_q;
      st_mem_d = st_ex_q;
    end
    if (memwb_en) begin
      v_wb_d  = !bubble_memwb && v_mem_q;
      rd_wb_d = bubble_memwb ? '0 : rd_mem_q;
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_ifid && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_ex_q      <= 1'b0;
      rd_ex_q     <= '0;
      rs1_ex_q    <= '0;
      rs2_ex_q    <= '0;
      ld_ex_q     <= 1'b0;
      st_ex_q     <= 1'b0;
      v_mem_q     <= 1'b0;
      rd_mem_q    <= '0;
      ld_mem_q    <= 1'b0;
      st_mem_q    <= 1'b0;
      v_wb_q      <= 1'b0;
      rd_wb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_ex_q      <= v_ex_d;
      rd_ex_q     <= rd_ex_d;
      rs1_ex_q    <= rs1_ex_d;
      rs2_ex_q    <= rs2_ex_d;
      ld_ex_q     <= ld_ex_d;
      st_ex_q     <= st_ex_d;
      v_mem_q     <= v_mem_d;
      rd_mem_q    <= rd_mem_d;
      ld_mem_q    <= ld_mem_d;
      st_mem_q    <= st_mem_d;
      v_wb_q      <= v_wb_d;
      rd_wb_q     <= rd_wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized scoreboard bench for pipeline_ctrl against a stage-shift reference model
// of the DLX pipeline; a small counter width makes saturation reachable.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam int          NCYC    = 3000;

  logic clk = 1'b0;
  logic reset, i_ready, mem_ready;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic id_load, id_store, id_pc_cmd_id, ex_taken;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic flush_ifid, bubble_idex, bubble_memwb;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .i_ready(i_ready), .mem_ready(mem_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_load(id_load), .id_store(id_store), .id_pc_cmd_id(id_pc_cmd_id),
    .ex_taken(ex_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
    .bubble_memwb(bubble_memwb), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit ld, st;
  } instr_t;

  typedef struct {
    bit pc, ifid, idex, exmem, memwb, fl, bi, bm;
    int fa, fb, sc, fc;
  } exp_t;

  exp_t   exp_q[$];
  instr_t ex_s, mem_s, wb_s, nop_i;
  int     sc, fc;
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     done     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    else n_pass++;
  endtask

  // Which older instruction supplies a source register to EX (0 regfile, 1 EX/MEM, 2 MEM/WB)
  function automatic int fwd_of(input int rs);
    if (mem_s.v && !mem_s.ld && mem_s.rd != 0 && mem_s.rd == rs) return 1;
    if (wb_s.v && wb_s.rd != 0 && wb_s.rd == rs) return 2;
    return 0;
  endfunction

  // Driver and reference model
  initial begin
    exp_t   e;
    instr_t id_i;
    bit     mwait, redir, lu;
    nop_i = '{v: 1'b0, rd: 0, rs1: 0, rs2: 0, ld: 1'b0, st: 1'b0};
    ex_s = nop_i; mem_s = nop_i; wb_s = nop_i;
    sc = 0; fc = 0;
    reset = 1'b1; i_ready = 1'b1; mem_ready = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_load = 1'b0; id_store = 1'b0; id_pc_cmd_id = 1'b0; ex_taken = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      reset        = (cyc < 2) || ($urandom_range(0, 99) < 2);
      i_ready      = $urandom_range(0, 99) < 80;
      mem_ready    = $urandom_range(0, 99) < 60;
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_rd        = 5'($urandom_range(0, 3));
      id_load      = $urandom_range(0, 99) < 30;
      id_store     = !id_load && ($urandom_range(0, 99) < 25);
      id_pc_cmd_id = $urandom_range(0, 99) < 10;
      ex_taken     = $urandom_range(0, 99) < 15;
      id_i = '{v: 1'b1, rd: int'(id_rd), rs1: int'(id_rs1), rs2: int'(id_rs2),
               ld: id_load, st: id_store};

      if (reset) begin
        ex_s = nop_i; mem_s = nop_i; wb_s = nop_i;
        sc = 0; fc = 0;
        e = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b0, memwb: 1'b0,
              fl: 1'b1, bi: 1'b1, bm: 1'b1, fa: 0, fb: 0, sc: 0, fc: 0};
      end else begin
        mwait = mem_s.v && (mem_s.ld || mem_s.st) && !mem_ready;
        redir = ex_taken && ex_s.v;
        lu    = ex_s.v && ex_s.ld && ex_s.rd != 0 &&
                (ex_s.rd == id_i.rs1 || ex_s.rd == id_i.rs2);
        e = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b1,
              fl: 1'b0, bi: 1'b0, bm: 1'b0,
              fa: fwd_of(ex_s.rs1), fb: fwd_of(ex_s.rs2), sc: sc, fc: fc};
        if (mwait) begin
          e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.bm = 1;
        end else if (redir) begin
          e.fl = 1; e.bi = 1;
        end else if (lu) begin
          e.pc = 0; e.ifid = 0; e.bi = 1;
        end else if (id_pc_cmd_id) begin
          e.pc = i_ready; e.fl = 1;
        end else if (!i_ready) begin
          e.pc = 0; e.fl = 1;
        end
        // A memory wait freezes the front and drains MEM into a WB bubble;
        // otherwise everything shifts, with a NOP entering EX on redirect/load-use.
        if (mwait) begin
          wb_s = nop_i;
        end else begin
          wb_s  = mem_s;
          mem_s = ex_s;
          ex_s  = (redir || lu) ? nop_i : id_i;
        end
        if (!e.pc && sc < CNT_MAX) sc++;
        if (e.fl && fc < CNT_MAX) fc++;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_en",        32'(pc_en),        32'(e.pc));
        check("ifid_en",      32'(ifid_en),      32'(e.ifid));
        check("idex_en",      32'(idex_en),      32'(e.idex));
        check("exmem_en",     32'(exmem_en),     32'(e.exmem));
        check("memwb_en",     32'(memwb_en),     32'(e.memwb));
        check("flush_ifid",   32'(flush_ifid),   32'(e.fl));
        check("bubble_idex",  32'(bubble_idex),  32'(e.bi));
        check("bubble_memwb", 32'(bubble_memwb), 32'(e.bm));
        check("fwd_a",        32'(fwd_a),        32'(e.fa));
        check("fwd_b",        32'(fwd_b),        32'(e.fb));
        check("stall_cnt",    32'(stall_cnt),    32'(e.sc));
        check("flush_cnt",    32'(flush_cnt),    32'(e.fc));
      end
    end
  end

  initial begin
    #(NCYC * 10 * 4);
    if (!done) begin
      $display("FAIL timeout: run did not complete, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
    end
  end

endmodule
